// File: rtl/cpu_pkg.sv
// Shared types and constants for the Lab4 CPU fetch path.
// Holds the fetch FSM states, PC constants and the word-alignment helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC            = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Instructions are word-sized, so the two low address bits are always dropped.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump > branch > sequential priority mux.
// Produces a word-aligned target plus a flag when a redirect target was misaligned.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_target,
  input  logic [31:0] seq_pc,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        misalign
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = seq_pc;
    redirect   = 1'b0;
    if (jump) begin
      raw_target = jump_target;
      redirect   = 1'b1;
    end else if (branch) begin
      raw_target = branch_target;
      redirect   = 1'b1;
    end
  end

  // Sequential values come straight from the adder and are never flagged.
  assign next_pc  = align_word(raw_target);
  assign misalign = redirect && (raw_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch sequencer with imem req/ack handshake.
// Redirects that land while a fetch is in flight are parked until that fetch's ack.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_pc_plus4,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_stall,
  input  logic        i_halt,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic        o_imem_req,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic        o_misalign,
  output logic        o_halted
);

  localparam logic [31:0] RESET_PC_ALIGNED = align_word(RESET_PC);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [31:0] pc;
  logic [31:0] pend_target;
  logic        pend_valid;
  logic        halt_pend;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        misalign;

  logic        imem_req;
  logic        halted;
  logic [31:0] sel_target;
  logic        sel_redirect;
  logic        sel_misalign;
  logic        ack_taken;
  logic        halt_seen;
  logic        halt_now;

  pc_next_sel u_next_sel (
    .jump          (i_jump),
    .jump_target   (i_jump_target),
    .branch        (i_branch_taken),
    .branch_target (i_branch_target),
    .seq_pc        (i_pc_plus4),
    .next_pc       (sel_target),
    .redirect      (sel_redirect),
    .misalign      (sel_misalign)
  );

  // An ack only counts while a request is actually outstanding.
  assign ack_taken = imem_req && i_imem_ack;
  assign halt_seen = i_halt || halt_pend;
  assign halt_now  = halt_seen && (ack_taken || !imem_req);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (halt_now) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    halted   = 1'b0;
    unique case (state)
      FETCH:   imem_req = !i_stall;
      HALTED:  halted   = 1'b1;
      default: ;
    endcase
  end

  // A parked redirect squashes the in-flight fetch when its ack finally returns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc          <= RESET_PC_ALIGNED;
      pend_target <= 32'd0;
      pend_valid  <= 1'b0;
      halt_pend   <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      misalign    <= 1'b0;
      if (state == FETCH) begin
        misalign <= sel_misalign;
        if (ack_taken) begin
          pend_valid <= 1'b0;
          halt_pend  <= 1'b0;
          if (sel_redirect) begin
            pc <= sel_target;
          end else if (pend_valid) begin
            pc <= pend_target;
          end else begin
            pc          <= sel_target;
            instr       <= i_imem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
          end
        end else if (imem_req) begin
          if (sel_redirect) begin
            pend_target <= sel_target;
            pend_valid  <= 1'b1;
          end
          if (i_halt) begin
            halt_pend <= 1'b1;
          end
        end else begin
          pend_valid <= 1'b0;
          halt_pend  <= 1'b0;
          if (sel_redirect) begin
            pc <= sel_target;
          end else if (pend_valid) begin
            pc <= pend_target;
          end
        end
      end
    end
  end

  assign o_pc          = pc;
  assign o_imem_req    = imem_req;
  assign o_instr       = instr;
  assign o_instr_pc    = instr_pc;
  assign o_instr_valid = instr_valid;
  assign o_misalign    = misalign;
  assign o_halted      = halted;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit with a behavioural +4 adder
// and an instruction memory whose data is derived from the fetch address.
module tb_pc_fetch_unit;
  import cpu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc_plus4;
  logic        i_branch_taken = 1'b0;
  logic [31:0] i_branch_target = 32'd0;
  logic        i_jump = 1'b0;
  logic [31:0] i_jump_target = 32'd0;
  logic        i_stall = 1'b0;
  logic        i_halt = 1'b0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic        o_imem_req;
  logic [31:0] o_instr;
  logic [31:0] o_instr_pc;
  logic        o_instr_valid;
  logic        o_misalign;
  logic        o_halted;

  int assertion_count = 0;
  int fail_count = 0;

  function automatic logic [31:0] instrFor(input logic [31:0] addr);
    return addr ^ 32'hC0DE_0000;
  endfunction

  assign i_pc_plus4   = o_pc + PC_INC;
  assign i_imem_rdata = i_imem_ack ? instrFor(o_pc) : 32'hDEAD_BEEF;

  always #5 i_clk = ~i_clk;

  pc_fetch_unit dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_pc_plus4      (i_pc_plus4),
    .i_branch_taken  (i_branch_taken),
    .i_branch_target (i_branch_target),
    .i_jump          (i_jump),
    .i_jump_target   (i_jump_target),
    .i_stall         (i_stall),
    .i_halt          (i_halt),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_pc            (o_pc),
    .o_imem_req      (o_imem_req),
    .o_instr         (o_instr),
    .o_instr_pc      (o_instr_pc),
    .o_instr_valid   (o_instr_valid),
    .o_misalign      (o_misalign),
    .o_halted        (o_halted)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertion_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's worth of inputs, then sample 1 ns after the rising edge.
  task automatic applyStimulus(input logic ack, input logic stall, input logic halt,
                               input logic jump, input logic [31:0] jt,
                               input logic branch, input logic [31:0] bt);
    i_imem_ack      = ack;
    i_stall         = stall;
    i_halt          = halt;
    i_jump          = jump;
    i_jump_target   = jt;
    i_branch_taken  = branch;
    i_branch_target = bt;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_pc"}, o_pc, 32'h0);
    checkOutput({tag, "_req"}, 32'(o_imem_req), 32'd0);
    checkOutput({tag, "_instr"}, o_instr, 32'h0);
    checkOutput({tag, "_instr_pc"}, o_instr_pc, 32'h0);
    checkOutput({tag, "_valid"}, 32'(o_instr_valid), 32'd0);
    checkOutput({tag, "_misalign"}, 32'(o_misalign), 32'd0);
    checkOutput({tag, "_halted"}, 32'(o_halted), 32'd0);
  endtask

  initial begin
    logic [31:0] exp_pc;

    repeat (2) @(posedge i_clk);
    #1;
    checkReset("reset");

    // Back-to-back fetches with ack tied high
    i_imem_ack = 1'b1;
    i_rst_n    = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t1_first_pc", o_pc, 32'h0);
    checkOutput("t1_first_req", 32'(o_imem_req), 32'd1);
    checkOutput("t1_first_valid", 32'(o_instr_valid), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      exp_pc = 32'(i) * 32'd4;
      checkOutput("t1_pc", o_pc, exp_pc);
      checkOutput("t1_valid", 32'(o_instr_valid), 32'd1);
      checkOutput("t1_instr_pc", o_instr_pc, exp_pc - 32'd4);
      checkOutput("t1_instr", o_instr, instrFor(exp_pc - 32'd4));
    end

    // Ack held off for three cycles at 0x10
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("t2_wait_pc", o_pc, 32'h10);
      checkOutput("t2_wait_req", 32'(o_imem_req), 32'd1);
      checkOutput("t2_wait_valid", 32'(o_instr_valid), 32'd0);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_pc", o_pc, 32'h14);
    checkOutput("t2_valid", 32'(o_instr_valid), 32'd1);
    checkOutput("t2_instr_pc", o_instr_pc, 32'h10);
    checkOutput("t2_instr", o_instr, instrFor(32'h10));
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t2_reach_20", o_pc, 32'h20);

    // Branch parked during a wait, squashing the in-flight fetch at 0x20
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h100);
    checkOutput("t3_held_pc", o_pc, 32'h20);
    checkOutput("t3_no_misalign", 32'(o_misalign), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t3_squash_valid", 32'(o_instr_valid), 32'd0);
    checkOutput("t3_pc", o_pc, 32'h100);

    // Jump beats branch in the ack cycle, then a misaligned parked jump
    applyStimulus(1, 0, 0, 1, 32'h200, 1, 32'h300);
    checkOutput("t4_prio_pc", o_pc, 32'h200);
    checkOutput("t4_prio_valid", 32'(o_instr_valid), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_seq_pc", o_pc, 32'h204);
    applyStimulus(0, 0, 0, 1, 32'h203, 0, 0);
    checkOutput("t4_misalign_hi", 32'(o_misalign), 32'd1);
    checkOutput("t4_park_pc", o_pc, 32'h204);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_misalign_lo", 32'(o_misalign), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_aligned_pc", o_pc, 32'h200);
    checkOutput("t4_squash_valid", 32'(o_instr_valid), 32'd0);

    // Stall drops the request; a redirect while stalled loads directly
    i_imem_ack = 1'b0;
    i_stall    = 1'b1;
    #1;
    checkOutput("stall_req", 32'(o_imem_req), 32'd0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("stall_pc", o_pc, 32'h200);
    checkOutput("stall_valid", 32'(o_instr_valid), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 1, 32'h40);
    checkOutput("stall_redirect_pc", o_pc, 32'h40);

    // Halt on the ack at 0x40: instruction delivered, then frozen
    applyStimulus(1, 0, 1, 0, 0, 0, 0);
    checkOutput("t5_valid", 32'(o_instr_valid), 32'd1);
    checkOutput("t5_instr_pc", o_instr_pc, 32'h40);
    checkOutput("t5_instr", o_instr, instrFor(32'h40));
    checkOutput("t5_halted", 32'(o_halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, (i == 4), 32'h800, 0, 0);
      checkOutput("t5_halt_req", 32'(o_imem_req), 32'd0);
      checkOutput("t5_halt_pc", o_pc, 32'h44);
      checkOutput("t5_halt_lvl", 32'(o_halted), 32'd1);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    checkReset("t5_reset");

    // Wrap-around through the adder, then an asynchronous reset mid-wait
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    i_rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_fetch_pc", o_pc, 32'h0);
    applyStimulus(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("t6_top_pc", o_pc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_wrap_pc", o_pc, 32'h0);
    checkOutput("t6_wrap_instr_pc", o_instr_pc, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_after_wrap_pc", o_pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_wait_instr", o_instr, instrFor(32'h0));
    #2;
    i_rst_n = 1'b0;
    #1;
    checkReset("t6_async");
    i_imem_ack = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_late_ack_valid", 32'(o_instr_valid), 32'd0);
    checkOutput("t6_late_ack_pc", o_pc, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertion_count, fail_count);
    $finish;
  end

endmodule
